ahb_lite_mem_arbiter: RTL
=========================

AHB_LITE_MEM_ARBITER -- requirements
Module: ahb_lite_mem_arbiter

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, AHB address width; DATA_WIDTH, default 32, AHB data width.
REQ-002 SHALL have one clock and one reset: the reset is asynchronous and active-high.
REQ-003 HCLK  in  1  sole clock; all state updates on its rising edge.
REQ-004 HRESET  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-channel request; bit g is channel g.
REQ-006 addr  in  2*ADDR_WIDTH  channel 0 in the low slice, channel 1 in the high slice.
REQ-007 write  in  2  per-channel direction: 1 = write.
REQ-008 size  in  6  per-channel HSIZE encoding; channel 0 is [2:0], channel 1 is [5:3].
REQ-009 wdata  in  2*DATA_WIDTH  per-channel write data; channel 0 in the low slice.
REQ-010 ack  out  2  one-cycle completion pulse per channel.
REQ-011 err  out  2  per-channel error flag; valid only while the matching ack bit is high.
REQ-012 rdata  out  DATA_WIDTH  read data of the last completed read.
REQ-013 HADDR, HBURST(3), HSEL, HSIZE(3), HTRANS(2), HWDATA, HWRITE  out  AHB-Lite master outputs; widths per the AHB-Lite protocol and the parameters.
REQ-014 HRDATA, HREADY, HRESP  in  AHB-Lite slave responses.

Function
REQ-015 SHALL implement the FSM states IDLE, ADDR and DATA; all outputs SHALL be registered or decoded from registered state only.
REQ-016 Effective request SHALL be req & ~ack; a channel whose ack is high that cycle is not eligible.
REQ-017 In IDLE with one eligible channel, SHALL grant that channel; with both eligible, SHALL grant the channel other than the last-granted one (round-robin). The last-granted register resets to 1, so channel 0 wins the first contention.
REQ-018 On grant, SHALL latch the winner's addr, write, size and wdata, update the last-granted register, and go to ADDR.
REQ-019 SHALL reject a granted request without any bus access, pulsing ack=1 and err=1 one cycle after the grant and returning to IDLE, when: size > 2, or (size==1 and addr[0]==1), or (size==2 and addr[1:0]!=0).
REQ-020 In ADDR, SHALL drive HSEL=1, HTRANS=NONSEQ (2'b10), HBURST=SINGLE (3'b000), and HADDR/HWRITE/HSIZE from the latched values; SHALL hold these while HREADY=0 and go to DATA on an edge with HREADY=1.
REQ-021 In DATA, SHALL drive HTRANS=IDLE (2'b00), HSEL=0, and HWDATA = latched wdata; HWDATA SHALL stay stable until the transfer completes.
REQ-022 In DATA, on an edge with HREADY=1: SHALL pulse ack[g]=1 for one cycle, set err[g]=HRESP, capture rdata=HRDATA if the transfer is a read and HRESP=0, and return to IDLE.
REQ-023 In DATA, HREADY=0 SHALL hold the state; this covers wait states and the first cycle of an error response.
REQ-024 rdata SHALL be unchanged by writes, errors and rejections.
REQ-025 Latency with zero wait states: req sampled in IDLE at edge N, address phase N+1..N+2, data phase N+2..N+3, ack high in cycle N+3..N+4. Each HREADY=0 cycle adds one cycle.
REQ-026 Outside ADDR, SHALL drive HTRANS=IDLE and HSEL=0; at most one transfer SHALL be outstanding at any time.
REQ-027 Requesters SHALL hold req and payload stable until their ack; the arbiter SHALL NOT sample the payload after grant.

Reset
REQ-028 While HRESET=1, SHALL hold the following values: state=IDLE, HADDR=0, HBURST=0, HSEL=0, HSIZE=0, HTRANS=0, HWDATA=0, HWRITE=0, ack=0, err=0, rdata=0, last-granted=1.
REQ-029 Reset asserted mid-transfer SHALL abort the transfer immediately (asynchronously) with no ack; after reset release, arbitration SHALL resume from IDLE.

Verification
REQ-030 Single write: req=01, addr0=4, size0=2, wdata0=0x11 -> one NONSEQ with HADDR=4, HWRITE=1; HWDATA=0x11 in the data phase; ack=01 and err=00 three cycles after the request is sampled.
REQ-031 Contention: req=11 continuously from reset -> bus grants alternate 0,1,0,1 (channel 0 first); each ack is a single-cycle pulse; a read to addr 4 returns the value written earlier.
REQ-032 Wait states: slave holds HREADY=0 for 2 cycles in the address phase and 1 cycle in the data phase -> HADDR and HTRANS are stable throughout; ack arrives 3 cycles later than in REQ-030.
REQ-033 Error response: two-cycle HRESP=1 (HREADY=0 then HREADY=1) -> ack[g]=1 and err[g]=1; rdata unchanged.
REQ-034 Misaligned request: size0=2, addr0=6 -> no NONSEQ on the bus; ack=01 and err=01 one cycle after the grant.
REQ-035 Reset mid-transfer: HRESET pulsed during the data phase -> outputs immediately at the REQ-028 values; no ack; the next request completes normally.

Source files
------------

// File: rtl/ahb_lite_mem_arbiter.sv
// Two-channel round-robin arbiter in front of a single AHB-Lite master port.
// Each granted request is checked for size/alignment, then issued as one
// SINGLE/NONSEQ transfer; completion is reported as a one-cycle ack pulse.
module ahb_lite_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic [1:0]              req,
    input  logic [2*ADDR_WIDTH-1:0] addr,
    input  logic [1:0]              write,
    input  logic [5:0]              size,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    output logic [1:0]              ack,
    output logic [1:0]              err,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [ADDR_WIDTH-1:0]   HADDR,
    output logic [2:0]              HBURST,
    output logic                    HSEL,
    output logic [2:0]              HSIZE,
    output logic [1:0]              HTRANS,
    output logic [DATA_WIDTH-1:0]   HWDATA,
    output logic                    HWRITE,
    input  logic [DATA_WIDTH-1:0]   HRDATA,
    input  logic                    HREADY,
    input  logic                    HRESP
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t                  state, state_n;
    logic                    lg, lg_n;          // last-granted channel
    logic                    gnt, gnt_n;        // channel owning the current transfer
    logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
    logic                    write_q, write_n;
    logic [2:0]              size_q, size_n;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
    logic [ADDR_WIDTH-1:0]   haddr_n;
    logic                    hsel_n, hwrite_n;
    logic [2:0]              hsize_n;
    logic [1:0]              htrans_n;
    logic [DATA_WIDTH-1:0]   hwdata_n;
    logic [1:0]              ack_n, err_n;
    logic [DATA_WIDTH-1:0]   rdata_n;
    logic [1:0]              elig;
    logic                    win;
    logic [1:0]              gnt_onehot;

    // Sizes above a word, or half/word accesses not naturally aligned, never reach the bus.
    function automatic logic is_rejected(input logic [2:0] sz, input logic [1:0] a);
        return (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a != 2'b00);
    endfunction

    // Only single transfers are ever issued.
    assign HBURST = 3'b000;

    // State, latched request payload and all registered outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state   <= ST_IDLE;
            lg      <= 1'b1;
            gnt     <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            wdata_q <= '0;
            HADDR   <= '0;
            HSEL    <= 1'b0;
            HSIZE   <= '0;
            HTRANS  <= TRANS_IDLE;
            HWDATA  <= '0;
            HWRITE  <= 1'b0;
            ack     <= '0;
            err     <= '0;
            rdata   <= '0;
        end else begin
            state   <= state_n;
            lg      <= lg_n;
            gnt     <= gnt_n;
            addr_q  <= addr_n;
            write_q <= write_n;
            size_q  <= size_n;
            wdata_q <= wdata_n;
            HADDR   <= haddr_n;
            HSEL    <= hsel_n;
            HSIZE   <= hsize_n;
            HTRANS  <= htrans_n;
            HWDATA  <= hwdata_n;
            HWRITE  <= hwrite_n;
            ack     <= ack_n;
            err     <= err_n;
            rdata   <= rdata_n;
        end
    end

    // Arbitration, transfer sequencing and next values of every registered output.
    always_comb begin
        state_n    = state;
        lg_n       = lg;
        gnt_n      = gnt;
        addr_n     = addr_q;
        write_n    = write_q;
        size_n     = size_q;
        wdata_n    = wdata_q;
        haddr_n    = HADDR;
        hsel_n     = HSEL;
        hsize_n    = HSIZE;
        htrans_n   = HTRANS;
        hwdata_n   = HWDATA;
        hwrite_n   = HWRITE;
        ack_n      = 2'b00;
        err_n      = 2'b00;
        rdata_n    = rdata;
        // A channel being acked this cycle is about to drop its request.
        elig       = req & ~ack;
        win        = 1'b0;
        gnt_onehot = gnt ? 2'b10 : 2'b01;

        case (state)
            ST_IDLE: begin
                if (elig != 2'b00) begin
                    win     = (elig == 2'b11) ? ~lg : elig[1];
                    gnt_n   = win;
                    lg_n    = win;
                    addr_n  = win ? addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr[ADDR_WIDTH-1:0];
                    write_n = win ? write[1] : write[0];
                    size_n  = win ? size[5:3] : size[2:0];
                    wdata_n = win ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
                    state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                // First ADDR cycle: bus not yet driven, decide between issue and reject.
                if (HTRANS != TRANS_NONSEQ) begin
                    if (is_rejected(size_q, addr_q[1:0])) begin
                        ack_n   = gnt_onehot;
                        err_n   = gnt_onehot;
                        state_n = ST_IDLE;
                    end else begin
                        hsel_n   = 1'b1;
                        htrans_n = TRANS_NONSEQ;
                        haddr_n  = addr_q;
                        hwrite_n = write_q;
                        hsize_n  = size_q;
                    end
                end else if (HREADY) begin
                    hsel_n   = 1'b0;
                    htrans_n = TRANS_IDLE;
                    hwdata_n = wdata_q;
                    state_n  = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HREADY) begin
                    ack_n = gnt_onehot;
                    err_n = HRESP ? gnt_onehot : 2'b00;
                    if (!write_q && !HRESP) begin
                        rdata_n = HRDATA;
                    end
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule
